// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: synchronises and debounces user keys, detects accepted edges into
// sticky pending bits, and raises a masked, registered interrupt request.
module key_irq_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             irq
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] accept, set_pend, w1c, wdata;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             irq_q, irq_d;

    // Write data above WIDTH has no destination.
    logic unused_wd;
    assign unused_wd = ^wd;
    assign wdata     = wd[WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != data_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    data_d[i] = sync2_q[i];
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        w1c    = '0;
        if (we) begin
            case (addr)
                2'd1:    mask_d = wdata;
                2'd2:    edge_d = wdata;
                2'd3:    w1c    = wdata;
                default: ;
            endcase
        end
        // Accepted level XOR edge polarity: new 1 with EDGE=0, or new 0 with EDGE=1.
        set_pend = accept & (data_d ^ edge_q);
        pend_d   = (pend_q & ~w1c) | set_pend;
        irq_d    = |(pend_q & mask_q);
    end

    always_comb begin
        case (addr)
            2'd0:    rd = 32'(data_q);
            2'd1:    rd = 32'(mask_q);
            2'd2:    rd = 32'(edge_q);
            default: rd = 32'(pend_q);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            data_q  <= data_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Bench for key_irq_ctrl: directed key scenarios plus randomized keys and register
// traffic, scored against a window-based behavioural model through a queue.
module tb_key_irq_ctrl;
    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] pin_in;
    logic [1:0]       addr;
    logic             we;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic             irq;

    key_irq_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .pin_in(pin_in), .addr(addr),
        .we(we), .wd(wd), .rd(rd), .irq(irq)
    );

    always #10 clk = ~clk;

    // Scoreboard: {irq, rd} expectations with a name, popped by the monitor.
    logic [32:0] q_val[$];
    string       q_name[$];
    event        smp;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] mon_exp;
    string       mon_nm;

    initial forever begin
        @(smp);
        n_cmp++;
        if (q_val.size() == 0) begin
            n_bad++;
            $display("FAIL monitor: DUT sampled with no expectation queued (rd=%08h irq=%0b)", rd, irq);
        end else begin
            mon_exp = q_val.pop_front();
            mon_nm  = q_name.pop_front();
            if ({irq, rd} !== mon_exp)
                begin
                    n_bad++;
                    $display("FAIL %s: got irq=%0b rd=%08h, want irq=%0b rd=%08h",
                             mon_nm, irq, rd, mon_exp[32], mon_exp[31:0]);
                end
        end
    end

    // Behavioural model: a level is accepted once the last DEB synchronised samples
    // all disagree with the current debounced level.
    logic [WIDTH-1:0] m_s1, m_s2, m_data, m_mask, m_edge, m_pend;
    logic             m_irq;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_nd, m_set, m_w1c;
    logic             m_all, m_ni;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_data = '0; m_mask = '0;
            m_edge = '0; m_pend = '0; m_irq = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_nd  = m_data;
            m_set = '0;
            for (int i = 0; i < WIDTH; i++) begin
                m_all = (hist.size() == DEB);
                for (int k = 0; k < hist.size(); k++)
                    if (hist[k][i] == m_data[i]) m_all = 1'b0;
                if (m_all) begin
                    m_nd[i] = ~m_data[i];
                    if (m_nd[i] != m_edge[i]) m_set[i] = 1'b1;
                end
            end
            m_ni  = |(m_pend & m_mask);
            m_w1c = (we && addr == 2'd3) ? wd[WIDTH-1:0] : '0;
            m_pend = (m_pend & ~m_w1c) | m_set;
            if (we && addr == 2'd1) m_mask = wd[WIDTH-1:0];
            if (we && addr == 2'd2) m_edge = wd[WIDTH-1:0];
            m_data = m_nd;
            m_irq  = m_ni;
            m_s2   = m_s1;
            m_s1   = pin_in;
        end
    end

    function automatic logic [31:0] mreg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_data);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_edge);
            default: return 32'(m_pend);
        endcase
    endfunction

    task automatic push_chk(input logic [1:0] a, input logic [31:0] v, input logic iv, input string nm);
        addr = a;
        q_val.push_back({iv, v});
        q_name.push_back(nm);
        #1 -> smp;
        #1;
    endtask

    task automatic expect_regs(input logic [31:0] d, input logic [31:0] m, input logic [31:0] e,
                               input logic [31:0] p, input logic iv, input string nm);
        push_chk(2'd0, d, iv, {nm, "/DATA"});
        push_chk(2'd1, m, iv, {nm, "/MASK"});
        push_chk(2'd2, e, iv, {nm, "/EDGE"});
        push_chk(2'd3, p, iv, {nm, "/PEND"});
    endtask

    task automatic chk_model(input string nm);
        for (int a = 0; a < 4; a++) push_chk(2'(a), mreg(2'(a)), m_irq, nm);
    endtask

    task automatic tick();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; pin_in = '0; we = 1'b0; addr = '0; wd = '0;
        repeat (2) @(negedge clk);
        expect_regs(0, 0, 0, 0, 1'b0, "reset_held");
        reset = 1'b0;
        repeat (6) tick();
        expect_regs(0, 0, 0, 0, 1'b0, "idle");

        // Clean press on bit 0, rising mode, enabled.
        wr(2'd1, 32'h1);
        pin_in[0] = 1'b1;
        repeat (5) tick();
        expect_regs(0, 1, 0, 0, 1'b0, "press_pre");
        tick();
        expect_regs(1, 1, 0, 1, 1'b0, "press_accept");
        tick();
        expect_regs(1, 1, 0, 1, 1'b1, "press_irq");
        wr(2'd3, 32'h1);
        expect_regs(1, 1, 0, 0, 1'b1, "w1c_landed");
        tick();
        expect_regs(1, 1, 0, 0, 1'b0, "w1c_irq_low");
        pin_in[0] = 1'b0;
        repeat (6) tick();
        expect_regs(0, 1, 0, 0, 1'b0, "release_rising_mode");

        // Three-cycle glitch is rejected.
        for (int k = 0; k < 10; k++) begin
            if (k == 0) pin_in[0] = 1'b1;
            if (k == 3) pin_in[0] = 1'b0;
            tick();
            expect_regs(0, 1, 0, 0, 1'b0, "glitch");
        end

        // Falling-edge mode on bit 1.
        wr(2'd2, 32'h2);
        wr(2'd1, 32'h2);
        pin_in[1] = 1'b1;
        repeat (6) tick();
        expect_regs(2, 2, 2, 0, 1'b0, "fall_press");
        pin_in[1] = 1'b0;
        repeat (6) tick();
        expect_regs(0, 2, 2, 2, 1'b0, "fall_release");
        tick();
        expect_regs(0, 2, 2, 2, 1'b1, "fall_irq");

        // Set and W1C on the same edge: set wins.
        wr(2'd3, 32'h2);
        wr(2'd1, 32'h1);
        pin_in[0] = 1'b1;
        repeat (6) tick();
        expect_regs(1, 1, 2, 1, 1'b0, "coll_first");
        pin_in[0] = 1'b0;
        repeat (6) tick();
        expect_regs(0, 1, 2, 1, 1'b1, "coll_release");
        pin_in[0] = 1'b1;
        repeat (5) tick();
        addr = 2'd3; wd = 32'h1; we = 1'b1;
        tick();
        expect_regs(1, 1, 2, 1, 1'b1, "coll_set_wins");
        wr(2'd3, 32'h1);
        expect_regs(1, 1, 2, 0, 1'b1, "w1c_idle");
        tick();
        expect_regs(1, 1, 2, 0, 1'b0, "w1c_idle_irq");

        // Asynchronous reset in the middle of a debounce count.
        pin_in = '0;
        repeat (3) tick();
        #1 reset = 1'b1;
        expect_regs(0, 0, 0, 0, 1'b0, "async_reset");
        pin_in = 8'h01;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        expect_regs(0, 0, 0, 0, 1'b0, "post_reset_pre");
        tick();
        expect_regs(1, 0, 0, 1, 1'b0, "post_reset_accept");
        tick();
        expect_regs(1, 0, 0, 1, 1'b0, "post_reset_masked");

        // Randomized keys and register traffic against the model.
        wr(2'd1, 32'hFF);
        for (int c = 0; c < 800; c++) begin
            chk_model("rand");
            if ($urandom_range(0, 4) == 0) pin_in[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) pin_in = WIDTH'($urandom);
            if (c == 400) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                addr = 2'($urandom_range(0, 3));
                wd   = $urandom;
                we   = 1'b1;
            end
            tick();
        end
        chk_model("rand_final");

        n_cmp++;
        if (q_val.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q_val.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
